// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback/commit stage:
// exception codes, ms_exc bit positions and the drain FSM state.
package wb_pkg;

    // Bit positions inside ms_exc.
    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_INT  = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ALE  = 9'd0;
    localparam logic [8:0] ESUBCODE_SYS  = 9'd0;
    localparam logic [8:0] ESUBCODE_BRK  = 9'd0;
    localparam logic [8:0] ESUBCODE_INE  = 9'd0;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Contents of the WS pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  exc;
        logic [31:0] vaddr;
        logic        ertn;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wvalue;
    } ws_t;

endpackage

// File: rtl/wb_exc_prio.sv
// Exception priority resolver: picks the highest-priority cause among
// interrupt and the instruction's exception flags, and reports its codes.
module wb_exc_prio
    import wb_pkg::*;
(
    input  logic [4:0] ms_exc,
    input  logic       has_int,
    output logic       sel_ale,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output logic       any_ex
);

    always_comb begin
        sel_ale  = 1'b0;
        ecode    = ECODE_INT;
        esubcode = ESUBCODE_INT;
        any_ex   = has_int | (|ms_exc);
        if (has_int) begin
            ecode    = ECODE_INT;
            esubcode = ESUBCODE_INT;
        end else if (ms_exc[EXC_ADEF]) begin
            ecode    = ECODE_ADEF;
            esubcode = ESUBCODE_ADEF;
        end else if (ms_exc[EXC_INE]) begin
            ecode    = ECODE_INE;
            esubcode = ESUBCODE_INE;
        end else if (ms_exc[EXC_SYS]) begin
            ecode    = ECODE_SYS;
            esubcode = ESUBCODE_SYS;
        end else if (ms_exc[EXC_BRK]) begin
            ecode    = ECODE_BRK;
            esubcode = ESUBCODE_BRK;
        end else if (ms_exc[EXC_ALE]) begin
            ecode    = ECODE_ALE;
            esubcode = ESUBCODE_ALE;
            sel_ale  = 1'b1;
        end
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback/commit stage: latches one instruction from MEM per cycle and either
// retires it or turns it into an exception/interrupt/ertn flush toward the CSR unit.
module wb_exc_commit
    import wb_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    // Handshake: an instruction moves MEM->WS on a cycle where ms_to_ws_valid
    // and ws_allowin are both high; an offer that is not accepted is dropped.
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [4:0]  ms_exc,
    input  logic [31:0] ms_vaddr,
    input  logic        ms_ertn,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_pc,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_vaddr,
    output logic        flush_valid,
    output logic [31:0] flush_target,
    output logic [31:0] instret,
    output state_t      dbg_state
);

    localparam logic [3:0] DRAIN_CNT = 4'(DRAIN_CYCLES);

    logic        ws_valid;
    ws_t         ws_q;
    ws_t         ms_bundle;
    logic        ws_live;
    logic        accept;
    logic        sel_ale;
    logic        any_ex;
    logic [5:0]  ecode;
    logic [8:0]  esubcode;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instret_q;

    assign ms_bundle = '{pc: ms_pc, exc: ms_exc, vaddr: ms_vaddr, ertn: ms_ertn,
                         rf_we: ms_rf_we, rf_waddr: ms_rf_waddr, rf_wdata: ms_rf_wdata,
                         csr_we: ms_csr_we, csr_num: ms_csr_num,
                         csr_wmask: ms_csr_wmask, csr_wvalue: ms_csr_wvalue};

    assign accept = ms_to_ws_valid & ws_allowin;

    always_ff @(posedge clk) begin
        if (reset) ws_valid <= 1'b0;
        else       ws_valid <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) ws_q <= ms_bundle;
    end

    // Masking with reset keeps every valid/we output low in the reset cycle itself.
    assign ws_live = ws_valid & ~reset;

    wb_exc_prio u_prio (
        .ms_exc   (ws_q.exc),
        .has_int  (has_int),
        .sel_ale  (sel_ale),
        .ecode    (ecode),
        .esubcode (esubcode),
        .any_ex   (any_ex)
    );

    assign wb_ex        = ws_live & any_ex;
    assign ertn_flush   = ws_live & ws_q.ertn & ~wb_ex;
    assign flush_valid  = wb_ex | ertn_flush;
    assign flush_target = wb_ex ? ex_entry : ertn_entry;
    assign wb_pc        = ws_q.pc;
    assign wb_ecode     = ecode;
    assign wb_esubcode  = esubcode;
    assign wb_vaddr     = sel_ale ? ws_q.vaddr : ws_q.pc;

    assign rf_we      = ws_live & ws_q.rf_we & ~flush_valid;
    assign rf_waddr   = ws_q.rf_waddr;
    assign rf_wdata   = ws_q.rf_wdata;
    assign csr_we     = ws_live & ws_q.csr_we & ~flush_valid;
    assign csr_num    = ws_q.csr_num;
    assign csr_wmask  = ws_q.csr_wmask;
    assign csr_wvalue = ws_q.csr_wvalue;

    always_ff @(posedge clk) begin
        if (reset)                      instret_q <= 32'd0;
        else if (ws_live & ~flush_valid) instret_q <= instret_q + 32'd1;
    end
    assign instret = instret_q;

    // Drain FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drain FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_valid && (DRAIN_CNT != 4'd0)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_CNT;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Drain FSM: outputs
    always_comb begin
        ws_allowin = (state_q == ST_RUN) & ~flush_valid;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Self-checking bench for wb_exc_commit: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_wb_exc_commit;

    localparam int DRAIN = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic [4:0]  ms_exc;
    logic [31:0] ms_vaddr;
    logic        ms_ertn;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask;
    logic [31:0] ms_csr_wvalue;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_vaddr;
    logic        flush_valid;
    logic [31:0] flush_target;
    logic [31:0] instret;
    wb_pkg::state_t dbg_state;

    wb_exc_commit #(.DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .reset(reset),
        .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_exc(ms_exc), .ms_vaddr(ms_vaddr), .ms_ertn(ms_ertn),
        .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr), .ms_rf_wdata(ms_rf_wdata),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_vaddr(wb_vaddr),
        .flush_valid(flush_valid), .flush_target(flush_target),
        .instret(instret), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the instruction sitting in WB, retired count, and the
    // first cycle number at which MEM may hand over again after a flush.
    int          cyc = 0;
    int          block_until = 0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc, m_vaddr, m_rf_wdata, m_csr_wmask, m_csr_wvalue;
    logic [4:0]  m_exc, m_rf_waddr;
    logic [13:0] m_csr_num;
    logic        m_ertn, m_rf_we, m_csr_we;
    logic [31:0] m_instret = 32'd0;
    logic        e_v, e_ex, e_ertn, e_flush, e_allow;
    logic [31:0] saved_instret;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Cause selection straight from the priority list INT > ADEF > INE > SYS > BRK > ALE.
    function automatic logic [5:0] ref_ecode(input logic intr, input logic [4:0] e);
        if (intr)      return 6'h00;
        if (e[0])      return 6'h08;
        if (e[1])      return 6'h0D;
        if (e[2])      return 6'h0B;
        if (e[3])      return 6'h0C;
        return 6'h09;
    endfunction

    task automatic sample();
        logic exp_rf, exp_csr;
        @(negedge clk);
        e_v     = m_valid && !reset;
        e_ex    = e_v && (has_int || (m_exc != 5'd0));
        e_ertn  = e_v && m_ertn && !e_ex;
        e_flush = e_ex || e_ertn;
        e_allow = (cyc >= block_until) && !e_flush;
        exp_rf  = e_v && !e_flush && m_rf_we;
        exp_csr = e_v && !e_flush && m_csr_we;
        check("rf_we", 32'(rf_we), 32'(exp_rf));
        if (exp_rf) begin
            check("rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
            check("rf_wdata", rf_wdata, m_rf_wdata);
        end
        check("csr_we", 32'(csr_we), 32'(exp_csr));
        if (exp_csr) begin
            check("csr_num", 32'(csr_num), 32'(m_csr_num));
            check("csr_wmask", csr_wmask, m_csr_wmask);
            check("csr_wvalue", csr_wvalue, m_csr_wvalue);
        end
        check("wb_ex", 32'(wb_ex), 32'(e_ex));
        check("ertn_flush", 32'(ertn_flush), 32'(e_ertn));
        check("flush_valid", 32'(flush_valid), 32'(e_flush));
        if (e_flush) check("flush_target", flush_target, e_ex ? ex_entry : ertn_entry);
        if (e_ex) begin
            check("wb_pc", wb_pc, m_pc);
            check("wb_ecode", 32'(wb_ecode), 32'(ref_ecode(has_int, m_exc)));
            check("wb_esubcode", 32'(wb_esubcode), 32'd0);
            check("wb_vaddr", wb_vaddr, (!has_int && m_exc == 5'b10000) ? m_vaddr : m_pc);
        end
        if (!reset) check("ws_allowin", 32'(ws_allowin), 32'(e_allow));
        check("instret", instret, m_instret);
    endtask

    task automatic advance();
        if (reset) begin
            m_valid     = 1'b0;
            m_instret   = 32'd0;
            block_until = 0;
        end else begin
            if (e_v && !e_flush) m_instret = m_instret + 32'd1;
            if (e_flush && DRAIN > 0) block_until = cyc + 1 + DRAIN;
            m_valid = ms_to_ws_valid && e_allow;
            if (m_valid) begin
                m_pc = ms_pc; m_exc = ms_exc; m_vaddr = ms_vaddr; m_ertn = ms_ertn;
                m_rf_we = ms_rf_we; m_rf_waddr = ms_rf_waddr; m_rf_wdata = ms_rf_wdata;
                m_csr_we = ms_csr_we; m_csr_num = ms_csr_num;
                m_csr_wmask = ms_csr_wmask; m_csr_wvalue = ms_csr_wvalue;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    // Driver tasks
    task automatic idle();
        ms_to_ws_valid = 1'b0;
        ms_pc = $urandom; ms_exc = 5'd0; ms_vaddr = $urandom; ms_ertn = 1'b0;
        ms_rf_we = 1'b0; ms_rf_waddr = 5'($urandom); ms_rf_wdata = $urandom;
        ms_csr_we = 1'b0; ms_csr_num = 14'($urandom);
        ms_csr_wmask = $urandom; ms_csr_wvalue = $urandom;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] exc, input logic [31:0] vaddr,
                         input logic ertn, input logic rfw, input logic csrw);
        ms_to_ws_valid = 1'b1;
        ms_pc = pc; ms_exc = exc; ms_vaddr = vaddr; ms_ertn = ertn;
        ms_rf_we = rfw; ms_rf_waddr = 5'($urandom_range(1, 31)); ms_rf_wdata = $urandom;
        ms_csr_we = csrw; ms_csr_num = 14'($urandom);
        ms_csr_wmask = $urandom; ms_csr_wvalue = $urandom;
    endtask

    task automatic idle_steps(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; has_int = 1'b0;
        ex_entry = 32'h1c00_8000; ertn_entry = 32'h1c00_0100;
        idle();
        step();
        step();
        reset = 1'b0;
        idle_steps(1);

        // Plain stream of three adds
        for (int i = 0; i < 3; i++) begin
            offer(32'h1c00_0000 + 32'(4 * i), 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            sample();
            check("stream_allowin", 32'(ws_allowin), 32'd1);
            advance();
        end
        idle_steps(1);
        sample();
        check("stream_instret", instret, 32'd3);
        advance();

        // SYS exception, then offers during the flush/drain window are refused
        offer(32'h1c00_0010, 5'b00100, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        offer(32'h1c00_0014, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        sample();
        check("sys_wb_ex", 32'(wb_ex), 32'd1);
        check("sys_ecode", 32'(wb_ecode), 32'h0B);
        check("sys_target", flush_target, 32'h1c00_8000);
        check("sys_rf_we", 32'(rf_we), 32'd0);
        check("sys_allowin0", 32'(ws_allowin), 32'd0);
        advance();
        for (int i = 1; i < 3; i++) begin
            sample();
            check("drain_allowin", 32'(ws_allowin), 32'd0);
            check("drain_no_commit", 32'(rf_we), 32'd0);
            advance();
        end
        idle();
        sample();
        check("after_drain_allowin", 32'(ws_allowin), 32'd1);
        advance();

        // ADEF and ALE together: ADEF wins, vaddr reports the pc
        ex_entry = $urandom;
        offer(32'h1c00_0020, 5'b10001, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        sample();
        check("adef_ecode", 32'(wb_ecode), 32'h08);
        check("adef_esub", 32'(wb_esubcode), 32'd0);
        check("adef_vaddr", wb_vaddr, 32'h1c00_0020);
        advance();
        idle_steps(3);

        // ALE alone with a CSR write attached
        offer(32'h1c00_0030, 5'b10000, 32'h1c00_0002, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        sample();
        check("ale_ecode", 32'(wb_ecode), 32'h09);
        check("ale_vaddr", wb_vaddr, 32'h1c00_0002);
        check("ale_csr_we", 32'(csr_we), 32'd0);
        advance();
        idle_steps(3);

        // Interrupt on a csrwr; then interrupt with an empty WB
        offer(32'h1c00_0040, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        has_int = 1'b1;
        sample();
        check("int_ecode", 32'(wb_ecode), 32'h00);
        check("int_csr_we", 32'(csr_we), 32'd0);
        check("int_wb_ex", 32'(wb_ex), 32'd1);
        advance();
        idle_steps(3);
        sample();
        check("int_empty_wb_ex", 32'(wb_ex), 32'd0);
        check("int_empty_flush", 32'(flush_valid), 32'd0);
        advance();
        has_int = 1'b0;

        // ertn, then reset in the middle of the drain
        ertn_entry = 32'h1c00_0100;
        offer(32'h1c00_0050, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        sample();
        saved_instret = instret;
        check("ertn_flush", 32'(ertn_flush), 32'd1);
        check("ertn_target", flush_target, 32'h1c00_0100);
        check("ertn_rf_we", 32'(rf_we), 32'd0);
        advance();
        reset = 1'b1;
        sample();
        check("ertn_instret_same", instret, saved_instret);
        advance();
        reset = 1'b0;
        sample();
        check("post_reset_allowin", 32'(ws_allowin), 32'd1);
        check("post_reset_instret", instret, 32'd0);
        advance();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) < 7)
                offer($urandom, ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                      $urandom, ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom));
            else
                idle();
            has_int    = ($urandom_range(0, 15) == 0);
            ex_entry   = $urandom;
            ertn_entry = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0; has_int = 1'b0;
        idle_steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
